// File: rtl/t_case_huge_pkg.sv
// Shared widths, sweep FSM state type and the signature fold used by t_case_huge_sweep.
package t_case_huge_pkg;

    localparam int unsigned DEF_IDX_W = 8;
    localparam int unsigned DEF_OUT_W = 10;
    localparam int unsigned DEF_SIG_W = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } sweep_state_t;

    // Rotate-left-by-1, then XOR in the zero-extended {idx, q} sample.
    function automatic logic [DEF_SIG_W-1:0] sig_fold(
        input logic [DEF_SIG_W-1:0] sig,
        input logic [DEF_IDX_W-1:0] idx,
        input logic [DEF_OUT_W-1:0] q
    );
        logic [DEF_SIG_W-1:0] w_sample;
        w_sample = DEF_SIG_W'({idx, q});
        return {sig[DEF_SIG_W-2:0], sig[DEF_SIG_W-1]} ^ w_sample;
    endfunction

endpackage

// File: rtl/t_case_huge_sig_acc.sv
// Signature/sample-count register pair: synchronous clear, fold-and-count on enable.
module t_case_huge_sig_acc
    import t_case_huge_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned SIG_W = DEF_SIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [OUT_W-1:0] i_q,
    output logic [SIG_W-1:0] o_sig,
    output logic [IDX_W:0]   o_count
);

    logic [SIG_W-1:0] r_sig;
    logic [IDX_W:0]   r_count;
    logic [SIG_W-1:0] w_sig_next;

    // Default widths reuse the package fold; other widths use the same rule inline.
    generate
        if (IDX_W == DEF_IDX_W && OUT_W == DEF_OUT_W && SIG_W == DEF_SIG_W) begin : g_pkg_fold
            assign w_sig_next = sig_fold(r_sig, i_idx, i_q);
        end else begin : g_generic_fold
            assign w_sig_next = {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ SIG_W'({i_idx, i_q});
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_sig   <= '0;
            r_count <= '0;
        end else if (i_en) begin
            r_sig   <= w_sig_next;
            r_count <= r_count + 1'b1;
        end
    end

    assign o_sig   = r_sig;
    assign o_count = r_count;

endmodule

// File: rtl/t_case_huge_sweep.sv
// Sweep sequencer feeding the huge-case lookup and folding its results into a signature.
// Optional T_CASE_HUGE_SWEEP_STALL_EN adds a 'stall' input that freezes an active sweep.
module t_case_huge_sweep
    import t_case_huge_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned SIG_W = DEF_SIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef T_CASE_HUGE_SWEEP_STALL_EN
    input  logic             stall,
`endif
    input  logic             start,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] index,
    input  logic [OUT_W-1:0] outq,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig,
    output logic [IDX_W:0]   count
);

    sweep_state_t     r_state;
    sweep_state_t     w_state_next;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_next;
    logic             w_clear;
    logic             w_fold;
    logic             w_stall;

`ifdef T_CASE_HUGE_SWEEP_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_clear      = 1'b0;
        w_fold       = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_next = StSweep;
                    w_index_next = first_idx;
                    w_clear      = 1'b1;
                end else if (r_state == StDone) begin
                    w_state_next = StIdle;
                end
            end
            StSweep: begin
                if (!w_stall) begin
                    w_fold = 1'b1;
                    // Last index stays on the bus so DONE reports where the sweep ended.
                    if (r_index == last_idx) begin
                        w_state_next = StDone;
                    end else begin
                        w_index_next = r_index + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    t_case_huge_sig_acc #(
        .IDX_W (IDX_W),
        .OUT_W (OUT_W),
        .SIG_W (SIG_W)
    ) u_sig_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_en    (w_fold),
        .i_idx   (r_index),
        .i_q     (outq),
        .o_sig   (sig),
        .o_count (count)
    );

    assign index = r_index;
    assign busy  = (r_state == StSweep);
    assign done  = (r_state == StDone);

endmodule

// File: tb/tb_t_case_huge_sweep.sv
// Directed bench for t_case_huge_sweep with a stand-in combinational lookup table.
module tb_t_case_huge_sweep;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  first_idx;
    logic [7:0]  last_idx;
    logic [7:0]  index;
    logic [9:0]  outq;
    logic        busy;
    logic        done;
    logic [63:0] sig;
    logic [8:0]  count;
`ifdef T_CASE_HUGE_SWEEP_STALL_EN
    logic        stall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Entries used by the directed signatures; other indices map to a fixed pattern.
    function automatic logic [9:0] lookup(input logic [7:0] idx);
        case (idx)
            8'h00:   lookup = 10'h001;
            8'he0:   lookup = 10'h05b;
            8'he1:   lookup = 10'h126;
            8'hff:   lookup = 10'h114;
            default: lookup = {2'b10, idx};
        endcase
    endfunction

    assign outq = lookup(index);

    t_case_huge_sweep dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef T_CASE_HUGE_SWEEP_STALL_EN
        .stall     (stall),
`endif
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .index     (index),
        .outq      (outq),
        .busy      (busy),
        .done      (done),
        .sig       (sig),
        .count     (count)
    );

    // Cycle 1 is the first cycle after the start edge; lat is the cycle done is seen.
    task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input int stall_at,
                             input int stall_len, input int restart_at, output int lat,
                             output int busy_n, output int done_n, output logic [63:0] sig2,
                             output logic [7:0] idx1, output logic [7:0] idx2);
        int cyc;
        lat    = 0;
        busy_n = 0;
        done_n = 0;
        sig2   = '0;
        idx1   = '0;
        idx2   = '0;
        @(negedge clk);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc <= 400 && (lat == 0 || cyc <= lat + 2)) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) lat = cyc;
            end
            if (cyc == 1) idx1 = index;
            if (cyc == 2) begin
                idx2 = index;
                sig2 = sig;
            end
            start = (cyc == restart_at);
`ifdef T_CASE_HUGE_SWEEP_STALL_EN
            stall = (cyc >= stall_at && cyc < stall_at + stall_len);
`else
            if (stall_at + stall_len != 0) $display("note: stall request ignored in this build");
`endif
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
`ifdef T_CASE_HUGE_SWEEP_STALL_EN
        stall = 1'b0;
`endif
        vectors++;
        if (lat == 0) begin
            miscompares++;
            $display("FAIL sweep_timeout first=%h last=%h: no done within 400 cycles", f, l);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        first_idx = 8'h00;
        last_idx  = 8'h00;
`ifdef T_CASE_HUGE_SWEEP_STALL_EN
        stall     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        vectors++; if (index !== 8'h00) begin miscompares++;
            $display("FAIL reset_index got %h want 00", index); end
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++;
            $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (sig !== 64'h0) begin miscompares++;
            $display("FAIL reset_sig got %h want 0", sig); end
        vectors++; if (count !== 9'h0) begin miscompares++;
            $display("FAIL reset_count got %h want 0", count); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_single();
        int lat, bn, dn;
        logic [63:0] s2;
        logic [7:0] i1, i2;
        run_sweep(8'h00, 8'h00, 0, 0, 0, lat, bn, dn, s2, i1, i2);
        vectors++; if (lat !== 2) begin miscompares++;
            $display("FAIL single_latency got %0d want 2", lat); end
        vectors++; if (bn !== 1) begin miscompares++;
            $display("FAIL single_busy_cycles got %0d want 1", bn); end
        vectors++; if (sig !== 64'h1) begin miscompares++;
            $display("FAIL single_sig got %h want 1", sig); end
        vectors++; if (count !== 9'h1) begin miscompares++;
            $display("FAIL single_count got %h want 1", count); end
        repeat (3) @(negedge clk);
        vectors++; if (sig !== 64'h1 || count !== 9'h1 || index !== 8'h00) begin miscompares++;
            $display("FAIL single_hold got sig=%h count=%h index=%h want 1 1 00",
                     sig, count, index); end
    endtask

    task automatic test_two();
        int lat, bn, dn;
        logic [63:0] s2;
        logic [7:0] i1, i2;
        run_sweep(8'he0, 8'he1, 0, 0, 0, lat, bn, dn, s2, i1, i2);
        vectors++; if (s2 !== 64'h3805b) begin miscompares++;
            $display("FAIL two_first_fold got %h want 3805b", s2); end
        vectors++; if (sig !== 64'h48590) begin miscompares++;
            $display("FAIL two_sig got %h want 48590", sig); end
        vectors++; if (count !== 9'h2) begin miscompares++;
            $display("FAIL two_count got %h want 2", count); end
        vectors++; if (lat !== 3) begin miscompares++;
            $display("FAIL two_latency got %0d want 3", lat); end
        vectors++; if (index !== 8'he1) begin miscompares++;
            $display("FAIL two_index_hold got %h want e1", index); end
    endtask

    task automatic test_wrap();
        int lat, bn, dn;
        logic [63:0] s2;
        logic [7:0] i1, i2;
        run_sweep(8'hff, 8'h00, 0, 0, 0, lat, bn, dn, s2, i1, i2);
        vectors++; if (i1 !== 8'hff || i2 !== 8'h00) begin miscompares++;
            $display("FAIL wrap_index_seq got %h,%h want ff,00", i1, i2); end
        vectors++; if (sig !== 64'h7fa29) begin miscompares++;
            $display("FAIL wrap_sig got %h want 7fa29", sig); end
        vectors++; if (count !== 9'h2) begin miscompares++;
            $display("FAIL wrap_count got %h want 2", count); end
    endtask

    task automatic test_full();
        int lat, bn, dn;
        logic [63:0] s2;
        logic [7:0] i1, i2;
        run_sweep(8'h01, 8'h00, 0, 0, 0, lat, bn, dn, s2, i1, i2);
        vectors++; if (count !== 9'h100) begin miscompares++;
            $display("FAIL full_count got %h want 100", count); end
        vectors++; if (bn !== 256) begin miscompares++;
            $display("FAIL full_busy_cycles got %0d want 256", bn); end
        vectors++; if (dn !== 1) begin miscompares++;
            $display("FAIL full_done_pulses got %0d want 1", dn); end
        vectors++; if (lat !== 257) begin miscompares++;
            $display("FAIL full_latency got %0d want 257", lat); end
    endtask

    task automatic test_ignore_start();
        int lat, bn, dn;
        logic [63:0] s2;
        logic [7:0] i1, i2;
        run_sweep(8'he0, 8'he1, 0, 0, 1, lat, bn, dn, s2, i1, i2);
        vectors++; if (sig !== 64'h48590) begin miscompares++;
            $display("FAIL ignore_start_sig got %h want 48590", sig); end
        vectors++; if (count !== 9'h2 || lat !== 3) begin miscompares++;
            $display("FAIL ignore_start_count_lat got %h/%0d want 2/3", count, lat); end
        vectors++; if (dn !== 1) begin miscompares++;
            $display("FAIL ignore_start_done_pulses got %0d want 1", dn); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        first_idx = 8'h00;
        last_idx  = 8'h00;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++;
            $display("FAIL b2b_first_done got %b want 1", done); end
        first_idx = 8'he0;
        last_idx  = 8'he1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (busy !== 1'b1 || done !== 1'b0 || index !== 8'he0) begin miscompares++;
            $display("FAIL b2b_restart got busy=%b done=%b index=%h want 1 0 e0",
                     busy, done, index); end
        @(negedge clk);
        vectors++; if (sig !== 64'h3805b) begin miscompares++;
            $display("FAIL b2b_first_fold got %h want 3805b", sig); end
        @(negedge clk);
        vectors++; if (done !== 1'b1 || sig !== 64'h48590 || count !== 9'h2) begin
            miscompares++;
            $display("FAIL b2b_second got done=%b sig=%h count=%h want 1 48590 2",
                     done, sig, count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int seen_busy = 0;
        int seen_done = 0;
        @(negedge clk);
        first_idx = 8'he0;
        last_idx  = 8'hff;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (index == 8'he5) found = 1'b1;
            else @(negedge clk);
        end
        vectors++; if (!found) begin miscompares++;
            $display("FAIL mid_reach_e5 got index=%h want e5 within 20 cycles", index); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (index !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin miscompares++;
            $display("FAIL mid_reset_ctrl got index=%h busy=%b done=%b want 00 0 0",
                     index, busy, done); end
        vectors++; if (sig !== 64'h0 || count !== 9'h0) begin miscompares++;
            $display("FAIL mid_reset_acc got sig=%h count=%h want 0 0", sig, count); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) seen_busy++;
            if (done) seen_done++;
        end
        vectors++; if (seen_busy != 0 || seen_done != 0) begin miscompares++;
            $display("FAIL mid_no_resume got busy_cycles=%0d done_cycles=%0d want 0 0",
                     seen_busy, seen_done); end
    endtask

`ifdef T_CASE_HUGE_SWEEP_STALL_EN
    task automatic test_stall();
        int lat, bn, dn;
        logic [63:0] s2;
        logic [7:0] i1, i2;
        run_sweep(8'he0, 8'he1, 2, 3, 0, lat, bn, dn, s2, i1, i2);
        vectors++; if (s2 !== 64'h3805b) begin miscompares++;
            $display("FAIL stall_first_fold got %h want 3805b", s2); end
        vectors++; if (sig !== 64'h48590 || count !== 9'h2) begin miscompares++;
            $display("FAIL stall_result got sig=%h count=%h want 48590 2", sig, count); end
        vectors++; if (lat !== 6 || bn !== 5) begin miscompares++;
            $display("FAIL stall_latency got lat=%0d busy=%0d want 6 5", lat, bn); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two();
        test_wrap();
        test_full();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef T_CASE_HUGE_SWEEP_STALL_EN
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
